// File: rtl/csr_issue_queue_if.sv
// Dispatch / writeback / ROB-head / issue bundle for csr_issue_queue.
// The master side drives dispatch, writeback and flush; the slave side is the queue.
interface csr_issue_queue_if #(
    parameter int TAG_W = 6,
    parameter int XLEN  = 32,
    parameter int UOP_W = 21
);
    logic             flush_i;
    logic             disp_valid_i;
    logic             disp_ready_o;
    logic [UOP_W-1:0] disp_uop_i;
    logic [TAG_W-1:0] disp_rob_tag_i;
    logic             disp_rs1_rdy_i;
    logic [TAG_W-1:0] disp_rs1_tag_i;
    logic [XLEN-1:0]  disp_rs1_data_i;
    logic             wb_valid_i;
    logic [TAG_W-1:0] wb_tag_i;
    logic [XLEN-1:0]  wb_data_i;
    logic [TAG_W-1:0] rob_head_tag_i;
    logic             csr_valid_o;
    logic [UOP_W-1:0] csr_uop_o;
    logic [XLEN-1:0]  csr_rs1_data_o;
    logic [TAG_W-1:0] csr_rob_tag_o;

    modport master (
        output flush_i, disp_valid_i, disp_uop_i, disp_rob_tag_i, disp_rs1_rdy_i,
               disp_rs1_tag_i, disp_rs1_data_i, wb_valid_i, wb_tag_i, wb_data_i,
               rob_head_tag_i,
        input  disp_ready_o, csr_valid_o, csr_uop_o, csr_rs1_data_o, csr_rob_tag_o
    );

    modport slave (
        input  flush_i, disp_valid_i, disp_uop_i, disp_rob_tag_i, disp_rs1_rdy_i,
               disp_rs1_tag_i, disp_rs1_data_i, wb_valid_i, wb_tag_i, wb_data_i,
               rob_head_tag_i,
        output disp_ready_o, csr_valid_o, csr_uop_o, csr_rs1_data_o, csr_rob_tag_o
    );
endinterface

// File: rtl/csr_issue_queue.sv
// In-order CSR holding queue in front of execute_csr. Entries wait for their rs1
// operand (captured at dispatch or snooped from writeback) and the head issues only
// once it is the ROB head, so CSR side effects are never speculative.
// The uop is carried as an opaque UOP_W-bit vector; XLEN is supplied directly.
// Optional feature macro: CSR_IQ_BYPASS_EN -- an empty queue forwards an already
// issuable uop straight into the output register at the dispatch edge.
module csr_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6,
    parameter int XLEN  = 32,
    parameter int UOP_W = 21
) (
    input  logic              clk_i,
    input  logic              rst_i,
    csr_issue_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_rdy;
    logic [UOP_W-1:0] ent_uop     [DEPTH];
    logic [TAG_W-1:0] ent_tag     [DEPTH];
    logic [TAG_W-1:0] ent_rs1_tag [DEPTH];
    logic [XLEN-1:0]  ent_data    [DEPTH];

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    logic push;
    logic push_q;
    logic pop;
    logic bypass;
    logic wb_hit_disp;

    // A same-cycle pop never frees a slot for the incoming uop.
    assign bus.disp_ready_o = (count_q < CNT_W'(DEPTH));

    // Handshake, head issue and optional bypass decisions for this cycle.
    always_comb begin
        push        = bus.disp_valid_i && bus.disp_ready_o && !bus.flush_i;
        pop         = ent_valid[head_q] && ent_rdy[head_q] &&
                      (ent_tag[head_q] == bus.rob_head_tag_i) && !bus.flush_i;
        wb_hit_disp = bus.wb_valid_i && (bus.wb_tag_i == bus.disp_rs1_tag_i);
`ifdef CSR_IQ_BYPASS_EN
        bypass      = push && (count_q == '0) && bus.disp_rs1_rdy_i &&
                      (bus.disp_rob_tag_i == bus.rob_head_tag_i);
`else
        bypass      = 1'b0;
`endif
        push_q      = push && !bypass;
    end

    // Queue storage, pointers, operand wakeup and the registered issue port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q             <= '0;
            tail_q             <= '0;
            count_q            <= '0;
            ent_valid          <= '0;
            bus.csr_valid_o    <= 1'b0;
            bus.csr_uop_o      <= '0;
            bus.csr_rs1_data_o <= '0;
            bus.csr_rob_tag_o  <= '0;
        end else if (bus.flush_i) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            ent_valid       <= '0;
            bus.csr_valid_o <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_valid[i] && !ent_rdy[i] && bus.wb_valid_i &&
                    (ent_rs1_tag[i] == bus.wb_tag_i)) begin
                    ent_rdy[i]  <= 1'b1;
                    ent_data[i] <= bus.wb_data_i;
                end
            end

            if (pop) begin
                ent_valid[head_q]  <= 1'b0;
                head_q             <= head_q + PTR_W'(1);
                bus.csr_uop_o      <= ent_uop[head_q];
                bus.csr_rs1_data_o <= ent_data[head_q];
                bus.csr_rob_tag_o  <= ent_tag[head_q];
            end

            if (bypass) begin
                bus.csr_uop_o      <= bus.disp_uop_i;
                bus.csr_rs1_data_o <= bus.disp_rs1_data_i;
                bus.csr_rob_tag_o  <= bus.disp_rob_tag_i;
            end

            // The tail slot is always free here, so it never collides with wakeup or pop.
            if (push_q) begin
                ent_valid[tail_q]   <= 1'b1;
                ent_uop[tail_q]     <= bus.disp_uop_i;
                ent_tag[tail_q]     <= bus.disp_rob_tag_i;
                ent_rs1_tag[tail_q] <= bus.disp_rs1_tag_i;
                if (bus.disp_rs1_rdy_i) begin
                    ent_rdy[tail_q]  <= 1'b1;
                    ent_data[tail_q] <= bus.disp_rs1_data_i;
                end else if (wb_hit_disp) begin
                    ent_rdy[tail_q]  <= 1'b1;
                    ent_data[tail_q] <= bus.wb_data_i;
                end else begin
                    ent_rdy[tail_q]  <= 1'b0;
                    ent_data[tail_q] <= '0;
                end
                tail_q <= tail_q + PTR_W'(1);
            end

            case ({push_q, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase

            bus.csr_valid_o <= pop || bypass;
        end
    end
endmodule
